job_dispatcher: RTL and testbench

- Sequences the pixel-job Queue and shares its output among NUM_CORES Mandelbrot iteration cores.
- Pops one job word at a time, allowing for the Queue's registered read (data valid one cycle after read).
- Holds the job and grants it round-robin to a ready core.
- Sits between the coordinate generator's job Queue and the core array.

---
 rtl/job_dispatcher_pkg.sv | 13 +
 rtl/job_dispatcher_arbiter.sv | 32 +++
 rtl/job_dispatcher.sv | 97 +++++++++
 tb/tb_job_dispatcher.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/job_dispatcher_pkg.sv
// Shared definitions for the job dispatcher: FSM state encoding and default sizes.
package dispatcher_defs;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_NUM_CORES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

endpackage

// File: rtl/job_dispatcher_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_index,
// wrapping at N-1, so non-power-of-two N never selects a nonexistent slot.
module round_robin_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = 2
) (
  input  logic [N-1:0]        request,
  input  logic [IDX_BITS-1:0] last_index,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_index,
  output logic                any_grant
);

  logic [IDX_BITS-1:0] idx;

  // Walk N candidates starting just after last_index; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    any_grant   = 1'b0;
    idx         = last_index;
    for (int k = 0; k < N; k++) begin
      idx = (idx >= IDX_BITS'(N - 1)) ? '0 : idx + IDX_BITS'(1);
      if (!any_grant && request[idx]) begin
        any_grant   = 1'b1;
        grant_index = idx;
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/job_dispatcher.sv
// Pops jobs from a registered-read Queue, holds each one and offers it
// round-robin to the first ready iteration core.
module job_dispatcher
  import dispatcher_defs::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int NUM_CORES  = DEFAULT_NUM_CORES,
  parameter int IDX_BITS   = 2,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  q_empty,
  output logic                  q_read,
  input  logic [WIDTH-1:0]      q_data,
  input  logic [NUM_CORES-1:0]  core_ready,
  output logic [NUM_CORES-1:0]  core_valid,
  output logic [WIDTH-1:0]      core_data,
  output logic [IDX_BITS-1:0]   last_core,
  output logic                  busy,
  output logic [COUNT_BITS-1:0] dispatch_count
);

  state_t                state;
  state_t                next_state;
  logic [WIDTH-1:0]      hold;
  logic                  load_hold;
  logic                  transfer;
  logic                  can_pop;
  logic [NUM_CORES-1:0]  grant_onehot;
  logic [IDX_BITS-1:0]   grant_idx;
  logic                  any_grant;

  round_robin_arbiter #(
    .N        (NUM_CORES),
    .IDX_BITS (IDX_BITS)
  ) u_arbiter (
    .request     (core_ready),
    .last_index  (last_core),
    .grant       (grant_onehot),
    .grant_index (grant_idx),
    .any_grant   (any_grant)
  );

  // Gated by reset_n so the read strobe stays low while reset is held.
  assign can_pop = reset_n & enable & ~q_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      hold           <= '0;
      last_core      <= IDX_BITS'(NUM_CORES - 1);
      dispatch_count <= '0;
    end else begin
      state <= next_state;
      if (load_hold) begin
        hold <= q_data;
      end
      if (transfer) begin
        last_core      <= grant_idx;
        dispatch_count <= dispatch_count + COUNT_BITS'(1);
      end
    end
  end

  // Unused encoding 3 falls into the default branch and behaves as IDLE.
  always_comb begin
    next_state = state;
    q_read     = 1'b0;
    core_valid = '0;
    load_hold  = 1'b0;
    transfer   = 1'b0;
    case (state)
      ST_LATCH: begin
        load_hold  = 1'b1;
        next_state = ST_OFFER;
      end
      ST_OFFER: begin
        if (any_grant) begin
          core_valid = grant_onehot;
          transfer   = 1'b1;
          q_read     = can_pop;
          next_state = can_pop ? ST_LATCH : ST_IDLE;
        end
      end
      default: begin
        q_read     = can_pop;
        next_state = can_pop ? ST_LATCH : ST_IDLE;
      end
    endcase
  end

  assign core_data = hold;
  assign busy      = (state == ST_LATCH) || (state == ST_OFFER);

endmodule

// File: tb/tb_job_dispatcher.sv
// Bench for job_dispatcher: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model.
module tb_job_dispatcher;

  localparam int NC = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          q_empty;
  logic          q_read;
  logic [31:0]   q_data = '0;
  logic [NC-1:0] core_ready;
  logic [NC-1:0] core_valid;
  logic [31:0]   core_data;
  logic [1:0]    last_core;
  logic          busy;
  logic [3:0]    dispatch_count;

  logic [31:0] mem [0:1023];
  int push_count = 0;
  int pop_count  = 0;

  int vectors     = 0;
  int miscompares = 0;
  int exp_last    = NC - 1;
  int exp_count   = 0;
  int deliv_idx   = 0;

  job_dispatcher #(
    .WIDTH      (32),
    .NUM_CORES  (NC),
    .IDX_BITS   (2),
    .COUNT_BITS (4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .q_empty        (q_empty),
    .q_read         (q_read),
    .q_data         (q_data),
    .core_ready     (core_ready),
    .core_valid     (core_valid),
    .core_data      (core_data),
    .last_core      (last_core),
    .busy           (busy),
    .dispatch_count (dispatch_count)
  );

  always #5 clock = ~clock;

  // Queue model with registered read: data appears the cycle after q_read.
  assign q_empty = (push_count == pop_count);
  always @(posedge clock) begin
    if (q_read) begin
      q_data    <= mem[pop_count];
      pop_count <= pop_count + 1;
    end
  end

  task automatic push(input logic [31:0] d);
    mem[push_count] = d;
    push_count++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NC-1:0] ready);
    for (int k = 1; k <= NC; k++) begin
      if (ready[(last + k) % NC]) return (last + k) % NC;
    end
    return -1;
  endfunction

  // Transaction-level model: every delivery goes to the next ready core in
  // rotation and carries the oldest job not yet delivered.
  task automatic monitor();
    int c;
    check("q_read_while_empty", 32'(q_read & q_empty), 32'd0);
    check("last_core", 32'(last_core), 32'(exp_last));
    check("dispatch_count", 32'(dispatch_count), 32'(exp_count % 16));
    if (core_valid !== '0) begin
      c = rr_pick(exp_last, core_ready);
      check("grant", 32'(core_valid), (c >= 0) ? (32'd1 << c) : 32'd0);
      check("core_data", core_data, mem[deliv_idx]);
      if (c >= 0) exp_last = c;
      deliv_idx++;
      exp_count++;
    end
  endtask

  task automatic step(input bit chk, input logic eqr, input logic [NC-1:0] ecv, input logic ebusy);
    @(negedge clock);
    if (chk) begin
      check("q_read", 32'(q_read), 32'(eqr));
      check("core_valid", 32'(core_valid), 32'(ecv));
      check("busy", 32'(busy), 32'(ebusy));
    end
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    exp_last  = NC - 1;
    exp_count = 0;
    deliv_idx = pop_count;
  endtask

  initial begin
    int target;
    reset_n    = 1'b0;
    enable     = 1'b1;
    core_ready = 4'b1111;
    push(32'h11);
    push(32'h22);
    push(32'h33);

    // Reset with a non-empty queue and enable high: nothing may move.
    step(1, 1'b0, 4'b0000, 1'b0);
    check("reset_core_data", core_data, 32'd0);
    reset_n = 1'b1;

    // Three jobs, all cores ready: q_read at 0,2,4, deliveries at 2,4,6.
    for (int c = 0; c < 8; c++) begin
      step(1, (c == 0 || c == 2 || c == 4),
           (c == 2) ? 4'b0001 : (c == 4) ? 4'b0010 : (c == 6) ? 4'b0100 : 4'b0000,
           (c >= 1 && c <= 6));
    end
    check("three_jobs_count", 32'(dispatch_count), 32'd3);

    // Job parked in OFFER with no ready core, then core 3 takes it.
    core_ready = 4'b0000;
    push(32'h5C);
    step(1, 1'b1, 4'b0000, 1'b0);
    step(1, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("held_data", core_data, 32'h5C);
      step(1, 1'b0, 4'b0000, 1'b1);
    end
    core_ready = 4'b1000;
    step(1, 1'b0, 4'b1000, 1'b1);
    step(1, 1'b0, 4'b0000, 1'b0);
    check("last_core_after_hold", 32'(last_core), 32'd3);

    // Only core 2 ready.
    core_ready = 4'b0100;
    push(32'hA5);
    step(1, 1'b1, 4'b0000, 1'b0);
    step(1, 1'b0, 4'b0000, 1'b1);
    step(1, 1'b0, 4'b0100, 1'b1);
    step(1, 1'b0, 4'b0000, 1'b0);
    check("last_core_only2", 32'(last_core), 32'd2);

    // Empty queue with enable high: idle throughout.
    core_ready = 4'b1111;
    for (int i = 0; i < 20; i++) step(1, 1'b0, 4'b0000, 1'b0);

    // enable dropped during LATCH: held job still delivered, no further pops.
    push(32'h77);
    push(32'h88);
    step(1, 1'b1, 4'b0000, 1'b0);
    enable = 1'b0;
    step(1, 1'b0, 4'b0000, 1'b1);
    step(1, 1'b0, 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) step(1, 1'b0, 4'b0000, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) push($urandom);
      enable     = ($urandom_range(7) != 0);
      core_ready = 4'($urandom);
      step(0, 1'b0, 4'b0000, 1'b0);
    end
    enable     = 1'b1;
    core_ready = 4'b1111;
    for (int i = 0; i < 400 && (deliv_idx < push_count || busy); i++) step(0, 1'b0, 4'b0000, 1'b0);
    check("drain_delivered", 32'(deliv_idx), 32'(push_count));
    check("drain_busy", 32'(busy), 32'd0);

    // Counter wrap: 17 jobs from reset leave a 4-bit count at 1.
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 17; i++) push(32'h100 + 32'(i));
    target = deliv_idx + 17;
    step(1, 1'b0, 4'b0000, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 80 && deliv_idx < target; i++) step(0, 1'b0, 4'b0000, 1'b0);
    check("wrap_jobs_delivered", 32'(deliv_idx), 32'(target));
    for (int i = 0; i < 10 && busy; i++) step(0, 1'b0, 4'b0000, 1'b0);
    check("wrap_count", 32'(dispatch_count), 32'd1);

    // Asynchronous reset while a job is parked in OFFER.
    core_ready = 4'b0000;
    push(32'hEE);
    step(1, 1'b1, 4'b0000, 1'b0);
    step(1, 1'b0, 4'b0000, 1'b1);
    check("offer_busy", 32'(busy), 32'd1);
    check("offer_data", core_data, 32'hEE);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_q_read", 32'(q_read), 32'd0);
    check("areset_core_valid", 32'(core_valid), 32'd0);
    check("areset_core_data", core_data, 32'd0);
    check("areset_last_core", 32'(last_core), 32'd3);
    check("areset_count", 32'(dispatch_count), 32'd0);
    model_reset();
    core_ready = 4'b1111;
    step(1, 1'b0, 4'b0000, 1'b0);
    reset_n = 1'b1;
    step(1, 1'b0, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
